// File: rtl/key_schedule_seq.sv
// PRESENT-80 key expansion sequencer: walks a loaded key through ROUNDS round keys
// and hands them out one per valid/ready transfer, plus the combinational round step.

module key_schedule (
  input  logic [79:0] x,
  input  logic [4:0]  i,
  output logic [79:0] y
);

  function automatic logic [3:0] sbox(input logic [3:0] v);
    logic [3:0] s;
    case (v)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      default: s = 4'h2;
    endcase
    return s;
  endfunction

  logic [79:0] rot;

  // rotate left by 61, S-box the top nibble, fold the round counter into bits 19..15
  always_comb begin
    rot       = {x[18:0], x[79:19]};
    y         = rot;
    y[79:76]  = sbox(rot[79:76]);
    y[19:15]  = rot[19:15] ^ i;
  end

endmodule

// state | meaning
// IDLE  | waiting for req; rk_valid low
// RUN   | presenting round key idx; advances on rk_ready
// DONE  | last key taken; one-cycle done pulse
module key_schedule_seq #(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [79:0] key,
  input  logic        abort,
  input  logic        rk_ready,
  output logic [63:0] rk,
  output logic [5:0]  rk_idx,
  output logic        rk_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS);

  state_t      state, state_nxt;
  logic [79:0] kreg;
  logic [5:0]  idx;
  logic [79:0] nxt;
  logic        load;
  logic        xfer;
  logic        advance;

  key_schedule u_ks (
    .x (kreg),
    .i (idx[4:0]),
    .y (nxt)
  );

  assign load    = (state == S_IDLE) && req && !abort;
  assign xfer    = (state == S_RUN) && rk_ready && !abort;
  // the final key is never stepped, so idx[4:0] cannot wrap into the round function
  assign advance = xfer && (idx < LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kreg <= '0;
      idx  <= '0;
    end else if (load) begin
      kreg <= key;
      idx  <= 6'd1;
    end else if (advance) begin
      kreg <= nxt;
      idx  <= idx + 6'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (req) state_nxt = S_RUN;
        S_RUN:   if (rk_ready && (idx == LAST_IDX)) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rk_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_RUN: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign rk     = kreg[79:16];
  assign rk_idx = idx;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq: zero key, stalls, reference key, abort,
// mid-run reset, ignored requests, and a two-round instance.

module tb_key_schedule_seq;

  localparam logic [63:0] SBOX_TAB = 64'h21748FE3DA09B65C;
  localparam logic [79:0] KEY_A    = 80'h9A60A70AB29A64D1E272;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [79:0] key;
  logic        abort;
  logic        rk_ready;
  logic [63:0] rk;
  logic [5:0]  rk_idx;
  logic        rk_valid;
  logic        busy;
  logic        done;

  logic        req2;
  logic [79:0] key2;
  logic        abort2;
  logic        rk_ready2;
  logic [63:0] rk2;
  logic [5:0]  rk_idx2;
  logic        rk_valid2;
  logic        busy2;
  logic        done2;

  int checks;
  int failures;

  key_schedule_seq #(.ROUNDS(32)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .key      (key),
    .abort    (abort),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .busy     (busy),
    .done     (done)
  );

  key_schedule_seq #(.ROUNDS(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req2),
    .key      (key2),
    .abort    (abort2),
    .rk_ready (rk_ready2),
    .rk       (rk2),
    .rk_idx   (rk_idx2),
    .rk_valid (rk_valid2),
    .busy     (busy2),
    .done     (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  // bit-by-bit reference of one PRESENT-80 key update
  function automatic logic [79:0] ks_ref(input logic [79:0] k, input int n);
    logic [79:0] r;
    logic [3:0]  top;
    for (int b = 0; b < 80; b++) r[(b + 61) % 80] = k[b];
    top = r[79:76];
    r[79:76] = SBOX_TAB[4*top +: 4];
    for (int j = 0; j < 5; j++) r[15 + j] = r[15 + j] ^ n[j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_key(input string tag, input int n, input logic [79:0] kref);
    chk({tag, "_valid"}, 80'(rk_valid), 80'(1));
    chk({tag, "_idx"}, 80'(rk_idx), 80'(n));
    chk({tag, "_rk"}, 80'(rk), 80'(kref[79:16]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 80'(rk_valid), 80'(0));
    chk({tag, "_busy"}, 80'(busy), 80'(0));
    chk({tag, "_done"}, 80'(done), 80'(0));
  endtask

  initial begin
    logic [79:0] kref;
    int          xfers;
    int          cyc;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req       = 1'b0;
    key       = '0;
    abort     = 1'b0;
    rk_ready  = 1'b1;
    req2      = 1'b0;
    key2      = '0;
    abort2    = 1'b0;
    rk_ready2 = 1'b1;

    tick;
    tick;
    chk_idle("reset");
    chk("reset_rk", 80'(rk), 80'(0));
    chk("reset_idx", 80'(rk_idx), 80'(0));

    // zero key, consumer always ready
    rst_n = 1'b1;
    key   = '0;
    req   = 1'b1;
    tick;
    req   = 1'b0;
    kref  = '0;
    xfers = 0;
    for (int n = 1; n <= 32; n++) begin
      chk_key("zero", n, kref);
      if (n == 2) chk("zero_k2_hand", 80'(rk), 80'(64'hC000000000000000));
      if (n == 3) chk("zero_k3_hand", 80'(rk), 80'(64'h5000180000000001));
      if (rk_valid && rk_ready) xfers++;
      kref = ks_ref(kref, n);
      tick;
    end
    chk("zero_xfers", 80'(xfers), 80'(32));
    chk("zero_done_t33", 80'(done), 80'(1));
    chk("zero_busy_t33", 80'(busy), 80'(1));
    chk("zero_valid_t33", 80'(rk_valid), 80'(0));
    tick;
    chk_idle("zero_t34");

    // stall on cycles 2..4: K2 held four cycles, done slips to t+36
    req = 1'b1;
    tick;
    req  = 1'b0;
    kref = '0;
    cyc  = 1;
    for (int n = 1; n <= 32; n++) begin
      chk_key("stall", n, kref);
      if (n == 2) begin
        rk_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick;
          cyc++;
          chk_key("stall_hold", 2, kref);
          chk("stall_hold_hand", 80'(rk), 80'(64'hC000000000000000));
        end
        rk_ready = 1'b1;
      end
      kref = ks_ref(kref, n);
      tick;
      cyc++;
    end
    chk("stall_done_cycle", 80'(cyc), 80'(36));
    chk("stall_done", 80'(done), 80'(1));
    tick;
    chk_idle("stall_after");

    // reference key: every emitted key follows from the previous by the round step
    key = KEY_A;
    req = 1'b1;
    tick;
    req = 1'b0;
    chk("ref_k1_hand", 80'(rk), 80'(64'h9A60A70AB29A64D1));
    kref = KEY_A;
    for (int n = 1; n <= 32; n++) begin
      chk_key("ref", n, kref);
      kref = ks_ref(kref, n);
      tick;
    end
    chk("ref_done", 80'(done), 80'(1));
    tick;
    chk_idle("ref_after");

    // abort at idx 10 while ready: nothing more emitted, no done pulse
    key = '0;
    req = 1'b1;
    tick;
    req  = 1'b0;
    kref = '0;
    for (int n = 1; n <= 10; n++) begin
      chk_key("abort_pre", n, kref);
      if (n < 10) begin
        kref = ks_ref(kref, n);
        tick;
      end
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_idle("abort_next");
    tick;
    chk_idle("abort_later");
    key = '0;
    req = 1'b1;
    tick;
    req = 1'b0;
    chk_key("abort_restart", 1, 80'(0));
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_idle("abort_clean");

    // reset at idx 20 with req held through reset
    key = KEY_A;
    req = 1'b1;
    tick;
    req  = 1'b0;
    kref = KEY_A;
    for (int n = 1; n <= 20; n++) begin
      chk_key("rst_pre", n, kref);
      if (n < 20) begin
        kref = ks_ref(kref, n);
        tick;
      end
    end
    rst_n = 1'b0;
    req   = 1'b1;
    tick;
    chk_idle("rst_next");
    chk("rst_next_rk", 80'(rk), 80'(0));
    chk("rst_next_idx", 80'(rk_idx), 80'(0));
    tick;
    chk_idle("rst_held_req");
    rst_n = 1'b1;
    req   = 1'b0;
    tick;
    chk_idle("rst_release");

    // req held high through RUN and DONE: no restart until IDLE, accepted at t+34
    key = '0;
    req = 1'b1;
    tick;
    kref = '0;
    for (int n = 1; n <= 32; n++) begin
      chk_key("hold", n, kref);
      kref = ks_ref(kref, n);
      tick;
    end
    chk("hold_done_t33", 80'(done), 80'(1));
    chk("hold_valid_t33", 80'(rk_valid), 80'(0));
    tick;
    chk_idle("hold_t34");
    tick;
    req = 1'b0;
    chk_key("hold_restart", 1, 80'(0));
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_idle("hold_clean");

    // two-round instance
    key2 = '0;
    req2 = 1'b1;
    tick;
    req2 = 1'b0;
    chk("r2_k1_valid", 80'(rk_valid2), 80'(1));
    chk("r2_k1_idx", 80'(rk_idx2), 80'(1));
    chk("r2_k1_rk", 80'(rk2), 80'(0));
    tick;
    chk("r2_k2_valid", 80'(rk_valid2), 80'(1));
    chk("r2_k2_idx", 80'(rk_idx2), 80'(2));
    chk("r2_k2_rk", 80'(rk2), 80'(64'hC000000000000000));
    tick;
    chk("r2_done", 80'(done2), 80'(1));
    chk("r2_done_valid", 80'(rk_valid2), 80'(0));
    chk("r2_done_busy", 80'(busy2), 80'(1));
    tick;
    chk("r2_idle_busy", 80'(busy2), 80'(0));
    chk("r2_idle_done", 80'(done2), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
